// File: rtl/sw_pkg.sv
// Shared types and helpers for the switch debouncer.
package sw_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  typedef enum logic {
    StStable  = ST_STABLE,
    StPending = ST_PENDING
  } db_state_e;

  // Width of the stability counter; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and two-state FSM.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulse_next_o
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s_sync;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign s_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (s_sync != db_q) begin
          state_d = StPending;
          cnt_d   = CW'(1);
        end
      end
      StPending: begin
        if (s_sync == db_q) begin
          // Level returned before the count completed: drop it silently.
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          db_d    = s_sync;
          rise_d  = s_sync;
          fall_d  = ~s_sync;
          state_d = StStable;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StStable;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o         = db_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign pulse_next_o = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW raw switch inputs and emits per-bit rise/fall pulses plus an
// any-edge flag.
module switch_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned N_SW          = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_any
);

  logic [N_SW-1:0] pulse_next;
  logic            sw_any_q, sw_any_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk         (clk),
      .rst         (rst),
      .raw_i       (sw_raw[i]),
      .db_o        (sw_db[i]),
      .rise_o      (sw_rise[i]),
      .fall_o      (sw_fall[i]),
      .pulse_next_o(pulse_next[i])
    );
  end

  // Built from the pulses' next state so sw_any lines up with them.
  assign sw_any_d = |pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_any_q <= 1'b0;
    end else begin
      sw_any_q <= sw_any_d;
    end
  end

  assign sw_any = sw_any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and random stimulus for switch_debouncer, checked every cycle
// against a run-length reference model.
module tb_switch_debouncer;

  localparam int unsigned NSW = 3;
  localparam int unsigned SS  = 2;
  localparam int unsigned SC  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_db, sw_rise, sw_fall;
  logic           sw_any;

  always #5 clk = ~clk;

  switch_debouncer #(
    .N_SW         (NSW),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any (sw_any)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model: raw levels delayed SS cycles, then a level is accepted
  // once it has differed from the output for SC consecutive cycles.
  logic [NSW-1:0] m_dly[SS];
  logic [NSW-1:0] m_db, m_rise, m_fall;
  logic           m_any;
  int             m_run[NSW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_db"},   32'(sw_db),   32'(m_db));
    check({tag, "_rise"}, 32'(sw_rise), 32'(m_rise));
    check({tag, "_fall"}, 32'(sw_fall), 32'(m_fall));
    check({tag, "_any"},  32'(sw_any),  32'(m_any));
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_dly[k] = '0;
    for (int i = 0; i < NSW; i++) m_run[i] = 0;
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
    m_any  = 1'b0;
  endtask

  task automatic model_step(input logic [NSW-1:0] raw);
    logic [NSW-1:0] s;
    s      = m_dly[SS-1];
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < NSW; i++) begin
      if (s[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == SC) begin
          m_db[i]   = s[i];
          m_rise[i] = s[i];
          m_fall[i] = ~s[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_any = |(m_rise | m_fall);
    for (int k = SS - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
    m_dly[0] = raw;
  endtask

  task automatic tick(input logic [NSW-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    model_step(raw);
    #1;
    check_all("cyc");
    pulse_cnt += $countones(sw_rise | sw_fall);
  endtask

  task automatic settle(input logic [NSW-1:0] raw, input int n);
    for (int k = 0; k < n; k++) tick(raw);
  endtask

  // Edge index (0 = first edge with the new level) where sw_db[idx] changes.
  task automatic edges_until(input int idx, input logic [NSW-1:0] raw, output int n);
    logic prev;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      prev = sw_db[idx];
      tick(raw);
      if (sw_db[idx] != prev) begin
        n = k;
        break;
      end
    end
  endtask

  int n;
  logic [NSW-1:0] r;

  initial begin
    // Reset with all switches high
    rst    = 1'b1;
    sw_raw = 3'b111;
    model_reset();
    #2;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    edges_until(0, 3'b111, n);
    check("s1_latency", 32'(n), 32'd5);
    check("s1_db", 32'(sw_db), 32'h7);
    check("s1_rise", 32'(sw_rise), 32'h7);
    check("s1_any", 32'(sw_any), 32'h1);
    tick(3'b111);
    check("s1_rise_once", 32'(sw_rise), 32'h0);
    check("s1_any_once", 32'(sw_any), 32'h0);

    // Clean rising edge on bit 0
    settle(3'b000, 8);
    pulse_cnt = 0;
    edges_until(0, 3'b001, n);
    check("s2_latency", 32'(n), 32'd5);
    check("s2_rise", 32'(sw_rise), 32'h1);
    tick(3'b001);
    check("s2_rise_once", 32'(sw_rise), 32'h0);
    settle(3'b001, 4);
    check("s2_pulses", 32'(pulse_cnt), 32'd1);

    // Glitch on bit 1 shorter than the stability window
    pulse_cnt = 0;
    settle(3'b011, 3);
    settle(3'b001, 8);
    check("s3_db", 32'(sw_db), 32'h1);
    check("s3_pulses", 32'(pulse_cnt), 32'd0);

    // Bounce on bit 2 before it holds high
    pulse_cnt = 0;
    tick(3'b101);
    tick(3'b001);
    tick(3'b101);
    tick(3'b001);
    edges_until(2, 3'b101, n);
    check("s4_latency", 32'(n), 32'd5);
    settle(3'b101, 6);
    check("s4_pulses", 32'(pulse_cnt), 32'd1);
    check("s4_db", 32'(sw_db), 32'h5);

    // Simultaneous fall on bit 0 and rise on bit 1
    edges_until(0, 3'b110, n);
    check("s5_latency", 32'(n), 32'd5);
    check("s5_fall", 32'(sw_fall), 32'h1);
    check("s5_rise", 32'(sw_rise), 32'h2);
    check("s5_any", 32'(sw_any), 32'h1);
    tick(3'b110);
    check("s5_any_once", 32'(sw_any), 32'h0);

    // Reset in the middle of a pending change on bit 0
    settle(3'b111, 4);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("s6_rst");
    check("s6_db_clear", 32'(sw_db), 32'h0);
    @(posedge clk);
    #1;
    check_all("s6_rst_hold");
    rst = 1'b0;
    edges_until(0, 3'b111, n);
    check("s6_latency", 32'(n), 32'd5);

    // Random toggling with an occasional reset
    r = 3'b111;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NSW; i++) begin
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      end
      if (c == 200) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      tick(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
